// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank read port.
// Optional feature macro: REG_BANK_READER_BYPASS_EN (write-data bypass on hazards).
package reg_bank_pkg;

  // Read-port controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rbr_state_t;

  // Default bank geometry
  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 8;

  // Upper bounds the selection helper is written for (64 entries x 64 bits)
  localparam int MAX_DEPTH = 64;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_BITS  = MAX_DEPTH * MAX_WIDTH;
  localparam int SEL_W     = $clog2(MAX_BITS);
  localparam int BIT_W     = $clog2(MAX_WIDTH);

  // Pick entry 'addr' out of a flattened Q bus whose entries are 'width' bits.
  // The bus is passed zero-extended to MAX_BITS so one helper serves any geometry.
  function automatic logic [MAX_WIDTH-1:0] entry_sel(
    input logic [MAX_BITS-1:0] bank_q,
    input int unsigned         width,
    input int unsigned         addr
  );
    logic [MAX_WIDTH-1:0] word;
    int unsigned          base;
    word = '0;
    base = addr * width;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      if ((b < width) && ((base + b) < MAX_BITS)) begin
        word[BIT_W'(b)] = bank_q[SEL_W'(base + b)];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/reg_bank_reader_if.sv
// Request/response channel between a consumer and the bank read port.
// Optional feature macro: REG_BANK_READER_BYPASS_EN (does not change this interface).
interface reg_bank_reader_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  // Consumer side: issues requests, accepts responses
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Reader side
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/reg_bank_mux.sv
// Combinational entry selector for the bank read port: picks the addressed
// word, flags out-of-range addresses and same-cycle writes to that entry.
// Optional feature macro: REG_BANK_READER_BYPASS_EN -- when defined, a hazard
// forwards wr_data instead of the (about to change) bank entry.
module reg_bank_mux
  import reg_bank_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] bank_q,
  input  logic [AW-1:0]          addr,
  input  logic [DEPTH-1:0]       wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       word,
  output logic                   hazard,
  output logic                   oob
);

  logic [MAX_BITS-1:0] q_ext;
  logic [WIDTH-1:0]    sel_word;
  logic [DEPTH-1:0]    hit_vec;

  assign q_ext    = MAX_BITS'(bank_q);
  assign sel_word = WIDTH'(entry_sel(q_ext, 32'(WIDTH), 32'(addr)));

  // Addresses past the last entry are only possible when DEPTH is not a power of two
  assign oob = (32'(addr) >= 32'(DEPTH));

  // One decode term per entry: that entry is addressed and being written this cycle
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit_vec[gi] = wr_en[gi] && (addr == AW'(gi));
  end

  // Out-of-range reads never see a hazard; other entries' writes are ignored
  assign hazard = (|hit_vec) && !oob;

  // Output word: zero for out-of-range, forwarded write data on a bypassed hazard
  always_comb begin
    word = sel_word;
    if (oob) begin
      word = '0;
    end
`ifdef REG_BANK_READER_BYPASS_EN
    else if (hazard) begin
      word = wr_data;
    end
`endif
  end

`ifndef REG_BANK_READER_BYPASS_EN
  // Write data is only forwarded in the bypass build
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;
`endif

endmodule

// File: rtl/reg_bank_reader.sv
// Read-port controller for the flip-flop register bank. Accepts a request,
// spends one READ cycle sampling the addressed entry, then holds the
// registered response until the consumer takes it.
// Optional feature macro: REG_BANK_READER_BYPASS_EN -- when defined, a write to
// the addressed entry during READ is forwarded; otherwise READ waits it out.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] bank_q,
  input  logic [DEPTH-1:0]       wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  reg_bank_reader_if.slave       bus
);

  localparam int AW = $clog2(DEPTH);

  rbr_state_t       state;
  logic [AW-1:0]    addr_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_err_reg;

  logic [WIDTH-1:0] word;
  logic             hazard;
  logic             oob;
  logic             sample_ok;

  reg_bank_mux #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mux (
    .bank_q  (bank_q),
    .addr    (addr_reg),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .word    (word),
    .hazard  (hazard),
    .oob     (oob)
  );

`ifdef REG_BANK_READER_BYPASS_EN
  // The mux already forwards wr_data, so READ always completes in one cycle
  logic unused_hazard;
  assign unused_hazard = hazard;
  assign sample_ok     = 1'b1;
`else
  // The entry's Q changes at this edge; wait for a write-free cycle
  assign sample_ok = !hazard;
`endif

  // Ready depends only on state and the consumer, never on req_valid/req_addr
  assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;

  // Request/response FSM with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_reg <= bus.req_addr;
            state    <= READ;
          end
        end
        READ: begin
          if (sample_ok) begin
            rsp_data_reg  <= word;
            rsp_err_reg   <= oob;
            rsp_valid_reg <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            // Response leaves this edge; a waiting request is taken on the same edge
            rsp_valid_reg <= 1'b0;
            if (bus.req_valid) begin
              addr_reg <= bus.req_addr;
              state    <= READ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
